uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- Parametrised oversampling UART receiver for the abcd-serial design; successor to the fixed 8N1 receive path in the serial top.
- Supports configurable baud, data width, parity and stop bits.
- Filters start glitches and majority-votes each bit.
- Buffers received words in a small FIFO with a valid/ready output.
- Sits between the board's uart_rx pin and the command/echo logic in top.

Parameters:
- CLK_HZ, 12_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit; must be even and ≥ 8.
- DATA_BITS, 8, data bits per frame; range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits checked; 1 or 2.
- FIFO_DEPTH, 4, receive buffer entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- uart_rx  in  1  asynchronous serial line; idles high.
- rx_data  out  DATA_BITS  head-of-FIFO word, LSB = first received bit.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- overflow  out  1  sticky: word dropped because the FIFO was full; cleared only by rst.
- busy  out  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset: all outputs 0, rx_data 0, FIFO empty, FSM in IDLE, tick divider 0, synchroniser flops loaded with 1.
- Synchroniser: uart_rx passes through 2 flops; all logic uses the synchronised value.
- Tick divider: DIV = round(CLK_HZ / (BAUD*OVERSAMPLE)); 78 at defaults. Emits a 1-cycle tick every DIV clocks. Restarts at 0 on start detection, so sample phase is aligned to the falling edge.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
- IDLE → START: on a synchronised high-to-low transition.
- START: at tick OVERSAMPLE/2 the line is voted.
  - Still low → DATA.
  - High (glitch) → IDLE with no output and no error.
- Bit sampling: majority of 3 samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within each bit period; the bit is decided on the third sample.
- DATA: shifts in DATA_BITS bits, LSB first. Then goes to PAR if PARITY≠0, else STOP.
- PAR: the voted bit is compared with the XOR of the data bits.
  - Odd mode: the XOR over data plus parity must be 1.
  - Even mode: that XOR must be 0.
- STOP: votes STOP_BITS bits.
  - All high and parity OK → word pushed to FIFO, then IDLE.
  - Any stop bit low → frame_err pulses and the word is discarded; go to WAIT_HIGH, which waits for the synchronised line to be 1, then IDLE.
  - Parity fail → parity_err pulses and the word is discarded; frame_err takes precedence if both apply.
- Latency: push occurs 1 clock after the last stop-bit vote; rx_valid rises on the next clock edge.
- FIFO:
  - Pop on rx_valid && rx_ready.
  - rx_data is registered and reflects the head entry whenever rx_valid = 1.
  - Push when full → word dropped, overflow set.
  - Simultaneous push and pop when full → both occur, no overflow.
  - Simultaneous push and pop when empty → word is pushed; rx_valid rises next cycle.
- Back-to-back frames: a start edge immediately after the stop-bit decision is accepted. No idle gap is required beyond the remainder of the stop bit.
- Reset mid-frame: returns to IDLE within 1 cycle, empties the FIFO, drops the partial word, clears overflow and suppresses pulses.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined:
  - Adds output break_det (1 bit).
  - Asserts while the line has been low continuously for ≥ (1+DATA_BITS+(PARITY≠0)+STOP_BITS)*OVERSAMPLE ticks.
  - Deasserts on the first synchronised high.
  - The associated frame_err still pulses once; no word is pushed.
- Undefined: port absent; a break is handled only as frame_err followed by WAIT_HIGH.

Decomposition:
- Package uart_pkg:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - FSM state enum;
  - function calc_div(clk_hz, baud, os) returning the rounded divisor;
  - function frame_bits(data_bits, parity, stop_bits).
- Sub-module uart_rx_fifo (parameters WIDTH, DEPTH):
  - synchronous FIFO with push/pop/full/empty;
  - power-of-two pointers with an extra wrap bit.

Test Plan (defaults unless noted, 12 MHz clk, 104 µs bit time):
- Idle high, then a 10 µs low pulse on uart_rx → rejected at mid-start; rx_valid, frame_err, parity_err and busy return to 0 within 60 µs.
- Send 0x68 ('h') 8N1 with rx_ready=1 → rx_valid pulses with rx_data=0x68, no error pulses.
- Send 0x01..0x06 back-to-back with rx_ready=0, FIFO_DEPTH=4 → 4 words held (0x01..0x04), overflow=1. Raise rx_ready → pops 0x01, 0x02, 0x03, 0x04 in order.
- PARITY=2, send 0x03 with parity bit 1 → parity_err pulse, no push. Resend with parity bit 0 → rx_data=0x03.
- Send 0x55 with stop bit driven low for 2 bit times → frame_err pulse, FSM holds in WAIT_HIGH until line high. A following 0xAA is received correctly.
- Assert rst during data bit 4 of 0x5A → busy=0 the next cycle, FIFO empty. The next full frame 0x5A is received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, receiver FSM states and divisor/frame-length helpers for uart_rx_os
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} rx_state_e;
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: power-of-two synchronous FIFO with wrap-bit pointers and a registered head word
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;
  logic [AW:0] wptr_q, rptr_q, rptr_d;
  logic wr, rd;
  assign empty_o = wptr_q == rptr_q;
  assign full_o = wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]};
  assign rd = pop_i && !empty_o;
  assign wr = push_i && (!full_o || rd);
  assign rptr_d = rptr_q + (AW+1)'(rd);
  assign dout_o = dout_q;
  always_ff @(posedge clk)
    if (wr) mem_q[wptr_q[AW-1:0]] <= din_i;
  always_ff @(posedge clk)
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
    end else begin
      wptr_q <= wptr_q + (AW+1)'(wr);
      rptr_q <= rptr_d;
      dout_q <= (rptr_d == wptr_q) ? din_i : mem_q[rptr_d[AW-1:0]];
    end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority vote, parity/stop checks and FIFO; break_det port via UART_RX_BREAK_DETECT_EN
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overflow,
  output logic                 busy
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                 break_det
`endif
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DW = $clog2(DIV + 1);
  localparam int PW = $clog2(OVERSAMPLE + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [PW-1:0] S1 = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] S2 = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] S3 = PW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] OS = PW'(OVERSAMPLE);
  rx_state_e state_q;
  logic [1:0] sync_q, smp_q;
  logic rx_prev_q, rx_s, tick, decide, vote, stop_ok, full, empty, pop;
  logic push_q, par_ok_q, stop_ok_q, frame_err_q, parity_err_q, ovf_q;
  logic [DW-1:0] div_q;
  logic [PW-1:0] ph_q, ph_n;
  logic [BW-1:0] bit_q;
  logic [DATA_BITS-1:0] shreg_q;
  assign rx_s = sync_q[1];
  assign tick = div_q == DW'(DIV - 1);
  assign ph_n = ph_q + PW'(1);
  assign decide = tick && ph_n == S3;
  assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign stop_ok = stop_ok_q & vote;
  assign pop = rx_valid & rx_ready;
  assign rx_valid = !empty;
  assign busy = state_q != IDLE;
  assign frame_err = frame_err_q;
  assign parity_err = parity_err_q;
  assign overflow = ovf_q;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
      smp_q <= '0;
      div_q <= '0;
      ph_q <= '0;
      bit_q <= '0;
      shreg_q <= '0;
      par_ok_q <= 1'b1;
      stop_ok_q <= 1'b1;
      push_q <= 1'b0;
      frame_err_q <= 1'b0;
      parity_err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], uart_rx};
      rx_prev_q <= rx_s;
      push_q <= 1'b0;
      frame_err_q <= 1'b0;
      parity_err_q <= 1'b0;
      ovf_q <= ovf_q | (push_q & full & ~pop);
      div_q <= tick ? '0 : div_q + DW'(1);
      if (tick) begin
        ph_q <= (ph_n == OS) ? '0 : ph_n;
        if (ph_n == S1) smp_q[0] <= rx_s;
        if (ph_n == S2) smp_q[1] <= rx_s;
      end
      case (state_q)
        IDLE:
          if (rx_prev_q && !rx_s) begin
            state_q <= START;
            div_q <= '0;
            ph_q <= '0;
          end
        START:
          if (decide) begin
            state_q <= vote ? IDLE : DATA;
            bit_q <= '0;
            par_ok_q <= 1'b1;
            stop_ok_q <= 1'b1;
          end
        DATA:
          if (decide) begin
            shreg_q <= {vote, shreg_q[DATA_BITS-1:1]};
            bit_q <= (bit_q == BW'(DATA_BITS - 1)) ? '0 : bit_q + BW'(1);
            if (bit_q == BW'(DATA_BITS - 1)) state_q <= (PARITY != PAR_NONE) ? PAR : STOP;
          end
        PAR:
          if (decide) begin
            par_ok_q <= ((^shreg_q) ^ vote) == (PARITY == PAR_ODD);
            state_q <= STOP;
          end
        STOP:
          if (decide) begin
            stop_ok_q <= stop_ok;
            bit_q <= bit_q + BW'(1);
            if (bit_q == BW'(STOP_BITS - 1)) begin
              state_q <= stop_ok ? IDLE : WAIT_HIGH;
              frame_err_q <= !stop_ok;
              parity_err_q <= stop_ok && !par_ok_q;
              push_q <= stop_ok && par_ok_q;
            end
          end
        WAIT_HIGH:
          if (rx_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  uart_rx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push_q),
    .din_i(shreg_q),
    .pop_i(pop),
    .dout_o(rx_data),
    .full_o(full),
    .empty_o(empty)
  );
`ifdef UART_RX_BREAK_DETECT_EN
  localparam int LIM = frame_bits(DATA_BITS, PARITY, STOP_BITS) * OVERSAMPLE;
  localparam int LW = $clog2(LIM + 1);
  logic [LW-1:0] low_q;
  always_ff @(posedge clk)
    if (rst || rx_s) low_q <= '0;
    else if (tick && low_q != LW'(LIM)) low_q <= low_q + LW'(1);
  assign break_det = (low_q == LW'(LIM)) && !rx_s;
`endif
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: randomized self-checking bench for uart_rx_os against a frame-level reference model
`timescale 1ns/1ps
module tb_uart_rx_os;
  localparam int CLK_HZ = 12_000_000;
  localparam int BAUD = 230_400;
  localparam int OS = 16;
  localparam int DEPTH = 4;
  localparam int BIT = int'(real'(CLK_HZ) / real'(BAUD * OS)) * OS;
  logic clk = 1'b0, rst = 1'b1, line = 1'b1, line_p = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data, rx_data_p;
  logic rx_valid, frame_err, parity_err, overflow, busy;
  logic rx_valid_p, frame_err_p, parity_err_p, overflow_p, busy_p;
  int n_cmp = 0, n_bad = 0, rdy_mode = 0;
  int fe_seen = 0, pe_seen = 0, fe_exp = 0, pe_exp = 0;
  int fe_seen_p = 0, pe_seen_p = 0, fe_exp_p = 0, pe_exp_p = 0;
  logic exp_ovf = 1'b0;
  logic [7:0] exp_q[$], exp_qp[$];
  always #41.667 clk = ~clk;
  uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .uart_rx(line), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err),
    .overflow(overflow), .busy(busy)
  );
  uart_rx_os #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(2),
               .FIFO_DEPTH(DEPTH)) u_par (
    .clk(clk), .rst(rst), .uart_rx(line_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .rx_ready(rx_ready), .frame_err(frame_err_p), .parity_err(parity_err_p),
    .overflow(overflow_p), .busy(busy_p)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (frame_err) fe_seen++;
      if (parity_err) pe_seen++;
      if (frame_err_p) fe_seen_p++;
      if (parity_err_p) pe_seen_p++;
      if (rx_valid && rx_ready) begin
        chk("pop", 32'(rx_data), exp_q.size() != 0 ? 32'(exp_q[0]) : 32'hDEAD);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (rx_valid_p && rx_ready) begin
        chk("pop_p", 32'(rx_data_p), exp_qp.size() != 0 ? 32'(exp_qp[0]) : 32'hDEAD);
        if (exp_qp.size() != 0) void'(exp_qp.pop_front());
      end
    end
  initial forever begin
    @(posedge clk);
    #1;
    rx_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end
  task automatic idle(input int k);
    if (k > 0) begin
      repeat (k) @(posedge clk);
      #1;
    end
  endtask
  task automatic send_bits(input logic p, input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      if (p) line_p = b[i];
      else line = b[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
  endtask
  task automatic send_frame(input logic p, input logic [7:0] d, input logic pb, input logic [1:0] st, input int gap);
    logic ok_s, ok_p;
    ok_s = p ? &st : st[0];
    ok_p = !p || !((^d) ^ pb);
    if (ok_s && ok_p) begin
      if (p) exp_qp.push_back(d);
      else if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ovf = 1'b1;
    end else if (!ok_s) begin
      if (p) fe_exp_p++;
      else fe_exp++;
    end else pe_exp_p++;
    if (p) send_bits(1'b1, {4'hF, st, pb, d, 1'b0}, 12);
    else send_bits(1'b0, {6'h3F, st[0], d, 1'b0}, 10);
    line = 1'b1;
    line_p = 1'b1;
    idle(ok_s ? gap : gap + BIT);
  endtask
  task automatic drain(input logic p);
    int k = 0;
    while ((p ? exp_qp.size() : exp_q.size()) != 0 && k < 8 * BIT) begin
      @(posedge clk);
      k++;
    end
    idle(2);
    chk(p ? "drain_p" : "drain", p ? exp_qp.size() : exp_q.size(), 0);
    chk(p ? "valid_low_p" : "valid_low", p ? rx_valid_p : rx_valid, 0);
  endtask
  initial begin
    logic [7:0] d;
    logic [1:0] st;
    idle(5);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_busy_p", busy_p, 0);
    rst = 1'b0;
    idle(BIT);
    line = 1'b0;
    idle(8);
    line = 1'b1;
    chk("glitch_busy", busy, 1);
    idle(BIT);
    chk("glitch_idle", busy, 0);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_fe", fe_seen, 0);
    chk("glitch_pe", pe_seen, 0);
    rdy_mode = 1;
    idle(2);
    send_frame(1'b0, 8'h68, 1'b0, 2'b11, BIT);
    drain(1'b0);
    chk("h_fe", fe_seen, fe_exp);
    chk("h_pe", pe_seen, pe_exp);
    rdy_mode = 0;
    idle(4);
    for (int v = 1; v <= 6; v++) send_frame(1'b0, 8'(v), 1'b0, 2'b11, 0);
    idle(BIT);
    chk("ovf_set", overflow, exp_ovf);
    chk("ovf_valid", rx_valid, 1);
    chk("ovf_head", rx_data, exp_q[0]);
    rdy_mode = 1;
    drain(1'b0);
    chk("ovf_sticky", overflow, exp_ovf);
    fe_exp++;
    send_bits(1'b0, {5'h1F, 2'b00, 8'h55, 1'b0}, 11);
    chk("wait_high_busy", busy, 1);
    line = 1'b1;
    idle(8);
    chk("wait_high_exit", busy, 0);
    chk("fe_count", fe_seen, fe_exp);
    chk("fe_no_push", rx_valid, 0);
    send_frame(1'b0, 8'hAA, 1'b0, 2'b11, BIT);
    drain(1'b0);
    send_bits(1'b0, {11'h0, 4'hA, 1'b0}, 5);
    line = 1'b1;
    idle(BIT / 2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_ovf", overflow, exp_ovf);
    idle(2 * BIT);
    send_frame(1'b0, 8'h5A, 1'b0, 2'b11, BIT);
    drain(1'b0);
    send_frame(1'b1, 8'h03, 1'b1, 2'b11, BIT);
    chk("par_bad_pe", pe_seen_p, pe_exp_p);
    chk("par_bad_nopush", rx_valid_p, 0);
    send_frame(1'b1, 8'h03, 1'b0, 2'b11, BIT);
    drain(1'b1);
    chk("par_fe", fe_seen_p, fe_exp_p);
    rdy_mode = 2;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      st = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'b11;
      send_frame(1'b0, d, 1'b0, st, $urandom_range(0, BIT / 2));
    end
    drain(1'b0);
    chk("rnd_fe", fe_seen, fe_exp);
    chk("rnd_pe", pe_seen, pe_exp);
    chk("rnd_ovf", overflow, exp_ovf);
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      st = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send_frame(1'b1, d, (^d) ^ ($urandom_range(0, 3) == 0), st, $urandom_range(0, BIT / 2));
    end
    drain(1'b1);
    chk("rnd_fe_p", fe_seen_p, fe_exp_p);
    chk("rnd_pe_p", pe_seen_p, pe_exp_p);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
